// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Sequencer for a shared, iterative RV32M multiply/divide unit sitting beside
//   the execute-stage ALU. One operation is accepted per request. It runs for
//   exactly ARCH_LEN cycles, one bit per cycle, with no early-out. The result is
//   held until the pipeline takes it.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   execute stage presents an M-extension op
//   req_ready   out  sequencer can accept (IDLE)
//   req_func3   in   000 MUL,001 MULH,010 MULHSU,011 MULHU,
//                    100 DIV,101 DIVU,110 REM,111 REMU
//   req_op1     in   rs1 (multiplicand / dividend)
//   req_op2     in   rs2 (multiplier / divisor)
//   flush_in    in   abort the current or pending op (older branch taken)
//   resp_valid  out  result valid (DONE)
//   resp_ready  in   pipeline consumes the result this cycle
//   resp_data   out  registered result, stable for the whole of DONE
//   busy_out    out  state != IDLE, used as the execute-stage stall
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int ARCH_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [2:0]          req_func3,
   input  logic [ARCH_LEN-1:0] req_op1,
   input  logic [ARCH_LEN-1:0] req_op2,
   input  logic                flush_in,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [ARCH_LEN-1:0] resp_data,
   output logic                busy_out
);

   localparam int W     = ARCH_LEN;
   localparam int CNT_W = $clog2(ARCH_LEN + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

   logic [1:0]       state_q,     state_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [2:0]       func3_q,     func3_d;
   logic             s1_q,        s1_d;
   logic             s2_q,        s2_d;
   logic             div_zero_q,  div_zero_d;
   logic             ovf_q,       ovf_d;
   logic [W-1:0]     op1_q,       op1_d;
   logic [W-1:0]     mcand_q,     mcand_d;
   logic [2*W-1:0]   prod_q,      prod_d;
   logic [W-1:0]     resp_data_q, resp_data_d;

   // ---------------- acceptance decode ----------------
   logic         accept;
   logic         op1_signed, op2_signed, req_s1, req_s2;
   logic [W-1:0] op1_mag, op2_mag;

   assign accept     = req_valid & req_ready & ~flush_in;
   assign op1_signed = (req_func3 == F_MULH) | (req_func3 == F_MULHSU) |
                       (req_func3 == F_DIV)  | (req_func3 == F_REM);
   assign op2_signed = (req_func3 == F_MULH) | (req_func3 == F_DIV) |
                       (req_func3 == F_REM);
   assign req_s1     = op1_signed & req_op1[W-1];
   assign req_s2     = op2_signed & req_op2[W-1];
   assign op1_mag    = req_s1 ? -req_op1 : req_op1;
   assign op2_mag    = req_s2 ? -req_op2 : req_op2;

   // ---------------- one iteration step ----------------
   // Multiply: prod holds {partial_high, remaining multiplier bits}; add the
   // multiplicand into the high half when the current multiplier bit is set,
   // then shift right. The W+1-bit sum keeps the carry.
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   // Divide: prod holds {partial remainder, dividend/quotient bits}; shift left
   // one bit and keep the trial subtraction only when it does not go negative.
   logic [W:0]     div_diff;
   logic [2*W-1:0] div_next;
   logic [2*W-1:0] step_prod;

   assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next  = {mul_sum, prod_q[W-1:1]};
   assign div_diff  = prod_q[2*W-1:W-1] - {1'b0, mcand_q};
   assign div_next  = div_diff[W] ? {prod_q[2*W-2:0], 1'b0}
                                  : {div_diff[W-1:0], prod_q[W-2:0], 1'b1};
   assign step_prod = func3_q[2] ? div_next : mul_next;

   // ---------------- final result (from the completing step) ----------------
   logic [2*W-1:0] prod_signed;
   logic [W-1:0]   quo_signed, rem_signed, result;

   assign prod_signed = (s1_q ^ s2_q) ? -step_prod : step_prod;
   assign quo_signed  = (s1_q ^ s2_q) ? -step_prod[W-1:0] : step_prod[W-1:0];
   assign rem_signed  = s1_q ? -step_prod[2*W-1:W] : step_prod[2*W-1:W];

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      result = '0;
      if (!func3_q[2]) begin
         result = (func3_q == F_MUL) ? prod_signed[W-1:0] : prod_signed[2*W-1:W];
      end else if (div_zero_q) begin
         result = func3_q[1] ? op1_q : '1;
      end else if (ovf_q) begin
         result = func3_q[1] ? '0 : MIN_INT;
      end else begin
         result = func3_q[1] ? rem_signed : quo_signed;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      func3_d     = func3_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      div_zero_d  = div_zero_q;
      ovf_d       = ovf_q;
      op1_d       = op1_q;
      mcand_d     = mcand_q;
      prod_d      = prod_q;
      resp_data_d = resp_data_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_BUSY;
               count_d    = '0;
               func3_d    = req_func3;
               s1_d       = req_s1;
               s2_d       = req_s2;
               div_zero_d = req_func3[2] & (req_op2 == '0);
               ovf_d      = ((req_func3 == F_DIV) | (req_func3 == F_REM)) &
                            (req_op1 == MIN_INT) & (req_op2 == '1);
               op1_d      = req_op1;
               mcand_d    = req_func3[2] ? op2_mag : op1_mag;
               prod_d     = {{W{1'b0}}, (req_func3[2] ? op1_mag : op2_mag)};
            end
         end
         ST_BUSY: begin
            if (flush_in) begin
               state_d = ST_IDLE;
            end else begin
               prod_d  = step_prod;
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(W - 1)) begin
                  state_d     = ST_DONE;
                  resp_data_d = result;
               end
            end
         end
         ST_DONE: begin
            // A flush alongside resp_ready still just drops the result.
            if (flush_in || resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         func3_q     <= '0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         div_zero_q  <= 1'b0;
         ovf_q       <= 1'b0;
         op1_q       <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         func3_q     <= func3_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         div_zero_q  <= div_zero_d;
         ovf_q       <= ovf_d;
         op1_q       <= op1_d;
         mcand_q     <= mcand_d;
         prod_q      <= prod_d;
         resp_data_q <= resp_data_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_DONE);
   assign busy_out   = (state_q != ST_IDLE);
   assign resp_data  = resp_data_q;

endmodule
